// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and control-word layout for the ID/EX pipeline controller
//
// Purpose : FSM state type, control-word field slices and bit indices, bubble
//           constant and the wait-counter width used by idex_hazard_ctrl.
// Ports   : none (package)

package pipe_ctrl_pkg;

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MDU_WAIT = 1'b1
   } state_t;

   // Control word layout: {EX[4:0], M[2:0], WB[1:0]}
   localparam int UC_W     = 10;
   localparam int UC_WB_LO = 0;
   localparam int UC_WB_HI = 1;
   localparam int UC_M_LO  = 2;
   localparam int UC_M_HI  = 4;
   localparam int UC_EX_LO = 5;
   localparam int UC_EX_HI = 9;
   localparam int M_W      = UC_M_HI - UC_M_LO + 1;

   // Bit indices inside the WB and M fields
   localparam int WB_REGWRITE = 0;
   localparam int WB_MEMTOREG = 1;
   localparam int M_MEMREAD   = 0;
   localparam int M_MEMWRITE  = 1;
   localparam int M_BRANCH    = 2;

   // Same bits expressed as absolute positions in the full control word
   localparam int UC_REGWRITE = UC_WB_LO + WB_REGWRITE;
   localparam int UC_MEMTOREG = UC_WB_LO + WB_MEMTOREG;
   localparam int UC_MEMREAD  = UC_M_LO + M_MEMREAD;
   localparam int UC_MEMWRITE = UC_M_LO + M_MEMWRITE;
   localparam int UC_BRANCH   = UC_M_LO + M_BRANCH;

   localparam logic [UC_W-1:0] UC_BUBBLE = 10'b0;

   // Wait counter must hold MDU_LAT-1 for MDU_LAT up to 32
   localparam int WCNT_W = 5;

   // A load is in flight when the M field has MemRead set
   function automatic logic m_is_load(input logic [M_W-1:0] m);
      logic [M_W-1:0] mask;
      mask = '0;
      mask[M_MEMREAD] = 1'b1;
      return (m & mask) != '0;
   endfunction

endpackage

// File: rtl/idex_hazard_ctrl_sat_counter.sv
// rtl/idex_hazard_ctrl_sat_counter.sv - saturating up-counter for pipeline performance events
//
// Purpose : counts cycles where inc is high; holds at all-ones instead of wrapping.
// Ports   : clk  in  1  rising-edge clock
//           rst  in  1  synchronous active-high clear
//           inc  in  1  count enable for this cycle
//           q    out W  current count

module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (inc && (r_q != {W{1'b1}})) begin
         r_q <= r_q + 1'b1;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/idex_hazard_ctrl.sv
// rtl/idex_hazard_ctrl.sv - ID/EX bubble, front-end enable and flush control for the 5-stage core
//
// Purpose : per cycle, chooses between passing the control word into ID/EX or a bubble,
//           and drives PC / IF/ID enables and the IF/ID flush. Resolves taken branches,
//           load-use hazards and fixed-latency MDU occupancy; keeps saturating stall and
//           flush counters.
// Ports   : clk              in   1      rising-edge clock
//           rst              in   1      synchronous active-high reset
//           id_uc            in   10     control word {EX,M,WB} from the control unit
//           id_rs / id_rt    in   5      source register fields of the instruction in ID
//           id_uses_rt       in   1      ID instruction reads rt
//           id_is_mdu        in   1      ID instruction is a multi-cycle MDU op
//           idex_m           in   3      M field held in ID/EX
//           idex_rt          in   5      rt destination held in ID/EX
//           ex_branch_taken  in   1      branch in EX resolved taken
//           uc_out           out  10     control word into ID/EX (0 = bubble)
//           pc_write         out  1      PC load enable
//           ifid_write       out  1      IF/ID load enable
//           ifid_flush       out  1      IF/ID clear
//           busy_mdu         out  1      waiting on an MDU op
//           stall_cnt        out  CNT_W  front-end stall cycles (saturating)
//           flush_cnt        out  CNT_W  branch flushes (saturating)

module idex_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [9:0]       id_uc,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_is_mdu,
   input  logic [2:0]       idex_m,
   input  logic [4:0]       idex_rt,
   input  logic             ex_branch_taken,
   output logic [9:0]       uc_out,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             busy_mdu,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(MDU_LAT - 1);

   state_t            r_state;
   logic [WCNT_W-1:0] r_wcnt;

   state_t            w_state_nxt;
   logic [WCNT_W-1:0] w_wcnt_nxt;
   logic              w_lu;
   logic              w_stall_inc;
   logic              w_flush_inc;

   // Register $zero is never a real dependency, so a load into r0 cannot stall.
   assign w_lu = m_is_load(idex_m) && (idex_rt != 5'd0) &&
                 ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

   always_comb begin
      uc_out      = UC_BUBBLE;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      w_stall_inc = 1'b0;
      w_flush_inc = 1'b0;

      if (rst) begin
         // Hold the front end and keep IF/ID cleared until reset releases.
         ifid_flush = 1'b1;
      end else begin
         unique case (r_state)
            ST_RUN: begin
               if (ex_branch_taken) begin
                  // Wrong-path instruction in ID (MDU or not) is dropped here.
                  ifid_flush  = 1'b1;
                  pc_write    = 1'b1;
                  ifid_write  = 1'b1;
                  w_flush_inc = 1'b1;
               end else if (w_lu) begin
                  // Bubble carries MemRead=0, so the hazard self-clears next cycle.
                  w_stall_inc = 1'b1;
               end else if (id_is_mdu) begin
                  uc_out      = id_uc;
                  pc_write    = 1'b1;
                  ifid_write  = 1'b1;
                  w_state_nxt = ST_MDU_WAIT;
                  w_wcnt_nxt  = WAIT_INIT;
               end else begin
                  uc_out     = id_uc;
                  pc_write   = 1'b1;
                  ifid_write = 1'b1;
               end
            end

            ST_MDU_WAIT: begin
               // EX holds only the MDU op or bubbles, so branch and load-use
               // inputs cannot be meaningful here and are ignored.
               w_stall_inc = 1'b1;
               w_wcnt_nxt  = r_wcnt - 1'b1;
               if (r_wcnt <= WCNT_W'(1)) begin
                  w_state_nxt = ST_RUN;
               end
            end

            default: begin
               w_state_nxt = ST_RUN;
               w_wcnt_nxt  = '0;
            end
         endcase
      end
   end

   assign busy_mdu = !rst && (r_state == ST_MDU_WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_stall_inc),
      .q   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_flush_inc),
      .q   (flush_cnt)
   );

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// tb/tb_idex_hazard_ctrl.sv - directed scoreboard bench for idex_hazard_ctrl

module tb_idex_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  id_uc;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        id_is_mdu;
   logic [2:0]  idex_m;
   logic [4:0]  idex_rt;
   logic        ex_branch_taken;

   logic [9:0]  uc_out;
   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic        busy_mdu;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   logic [9:0]  s_uc_out;
   logic        s_pc_write;
   logic        s_ifid_write;
   logic        s_ifid_flush;
   logic        s_busy_mdu;
   logic [1:0]  s_stall_cnt;
   logic [1:0]  s_flush_cnt;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string       tag;
      logic [9:0]  uc;
      logic        pc;
      logic        ifw;
      logic        fl;
      logic        busy;
      logic [15:0] st;
      logic [15:0] fc;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   idex_hazard_ctrl #(.MDU_LAT(4), .CNT_W(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_uc           (id_uc),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .id_is_mdu       (id_is_mdu),
      .idex_m          (idex_m),
      .idex_rt         (idex_rt),
      .ex_branch_taken (ex_branch_taken),
      .uc_out          (uc_out),
      .pc_write        (pc_write),
      .ifid_write      (ifid_write),
      .ifid_flush      (ifid_flush),
      .busy_mdu        (busy_mdu),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   idex_hazard_ctrl #(.MDU_LAT(4), .CNT_W(2)) dut_small (
      .clk             (clk),
      .rst             (rst),
      .id_uc           (id_uc),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .id_is_mdu       (id_is_mdu),
      .idex_m          (idex_m),
      .idex_rt         (idex_rt),
      .ex_branch_taken (ex_branch_taken),
      .uc_out          (s_uc_out),
      .pc_write        (s_pc_write),
      .ifid_write      (s_ifid_write),
      .ifid_flush      (s_ifid_flush),
      .busy_mdu        (s_busy_mdu),
      .stall_cnt       (s_stall_cnt),
      .flush_cnt       (s_flush_cnt)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Push the expectation for the current inputs, sample mid-cycle, then
   // advance past the next rising edge.
   task automatic step(input string tag, input logic [9:0] e_uc, input logic e_pc,
                       input logic e_ifw, input logic e_fl, input logic e_busy,
                       input int e_st, input int e_fc);
      exp_t e;
      e.tag  = tag;
      e.uc   = e_uc;
      e.pc   = e_pc;
      e.ifw  = e_ifw;
      e.fl   = e_fl;
      e.busy = e_busy;
      e.st   = 16'(e_st);
      e.fc   = 16'(e_fc);
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 16'd1, 16'd0);
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_uc"},    16'(uc_out),     16'(e.uc));
         chk({e.tag, "_pcw"},   16'(pc_write),   16'(e.pc));
         chk({e.tag, "_ifw"},   16'(ifid_write), 16'(e.ifw));
         chk({e.tag, "_flush"}, 16'(ifid_flush), 16'(e.fl));
         chk({e.tag, "_busy"},  16'(busy_mdu),   16'(e.busy));
         chk({e.tag, "_stc"},   stall_cnt,       e.st);
         chk({e.tag, "_flc"},   flush_cnt,       e.fc);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst             = 1'b1;
      id_uc           = 10'h155;
      id_rs           = 5'd0;
      id_rt           = 5'd0;
      id_uses_rt      = 1'b0;
      id_is_mdu       = 1'b0;
      idex_m          = 3'b000;
      idex_rt         = 5'd0;
      ex_branch_taken = 1'b0;
      @(posedge clk);
      #1;

      // Reset held two cycles
      step("rst_a", 10'h000, 0, 0, 1, 0, 0, 0);
      step("rst_b", 10'h000, 0, 0, 1, 0, 0, 0);
      rst = 1'b0;
      step("run_norm", 10'h155, 1, 1, 0, 0, 0, 0);

      // Load-use on rs
      idex_m = 3'b001; idex_rt = 5'd5; id_rs = 5'd5; id_uc = 10'h2A3;
      step("lu_stall", 10'h000, 0, 0, 0, 0, 0, 0);
      idex_m = 3'b000;
      step("lu_clear", 10'h2A3, 1, 1, 0, 0, 1, 0);

      // Load into r0 never stalls
      idex_m = 3'b001; idex_rt = 5'd0; id_rs = 5'd0;
      step("lu_rt0", 10'h2A3, 1, 1, 0, 0, 1, 0);

      // rt matches but is not a source
      idex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
      step("lu_rt_unused", 10'h2A3, 1, 1, 0, 0, 1, 0);
      id_uses_rt = 1'b1;
      step("lu_rt_used", 10'h000, 0, 0, 0, 0, 1, 0);

      // Store/branch in ID/EX without MemRead is not a load
      idex_m = 3'b110;
      step("no_memread", 10'h2A3, 1, 1, 0, 0, 2, 0);

      // Branch beats load-use
      idex_m = 3'b001; ex_branch_taken = 1'b1;
      step("br_over_lu", 10'h000, 1, 1, 1, 0, 2, 0);
      ex_branch_taken = 1'b0; idex_m = 3'b000; id_uses_rt = 1'b0;
      step("br_after", 10'h2A3, 1, 1, 0, 0, 2, 1);

      // MDU issue then three frozen cycles
      id_is_mdu = 1'b1; id_uc = 10'h3C1;
      step("mdu_issue", 10'h3C1, 1, 1, 0, 0, 2, 1);
      id_is_mdu = 1'b0; id_uc = 10'h0F0;
      step("mdu_w1", 10'h000, 0, 0, 0, 1, 2, 1);
      ex_branch_taken = 1'b1;
      step("mdu_w2_br", 10'h000, 0, 0, 0, 1, 3, 1);
      ex_branch_taken = 1'b0; idex_m = 3'b001; idex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
      step("mdu_w3_lu", 10'h000, 0, 0, 0, 1, 4, 1);
      idex_m = 3'b000; id_uses_rt = 1'b0;
      step("mdu_done", 10'h0F0, 1, 1, 0, 0, 5, 1);

      // Reset aborts an MDU wait
      id_is_mdu = 1'b1; id_uc = 10'h3C1;
      step("mdu2_issue", 10'h3C1, 1, 1, 0, 0, 5, 1);
      id_is_mdu = 1'b0; id_uc = 10'h0F0;
      step("mdu2_w1", 10'h000, 0, 0, 0, 1, 5, 1);
      rst = 1'b1;
      step("rst_in_wait", 10'h000, 0, 0, 1, 0, 6, 1);
      rst = 1'b0;
      step("after_abort", 10'h0F0, 1, 1, 0, 0, 0, 0);

      // Five consecutive stalls; the 2-bit counter must stop at 3
      idex_m = 3'b001; idex_rt = 5'd9; id_rs = 5'd9;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("sat2_pre%0d", i), 16'(s_stall_cnt), 16'((i > 3) ? 3 : i));
         step($sformatf("sat_%0d", i), 10'h000, 0, 0, 0, 0, i, 0);
      end
      idex_m = 3'b000;
      step("sat_end", 10'h0F0, 1, 1, 0, 0, 5, 0);
      chk("sat2_stall", 16'(s_stall_cnt), 16'd3);
      chk("sat2_flush", 16'(s_flush_cnt), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
